// File: rtl/exc_vector_unit.sv
// Exception vector unit.
// Each source keeps one pending exception and its instruction number. The
// oldest pending exception wins arbitration and is presented as a registered
// vector until the commit stage acknowledges it. Age is measured relative
// to head_inum, so instruction-number wrap-around is handled naturally.
//
// Handshake: exc_valid rises when a vector is issued. exc_valid,
// exc_handler_addr, exc_inst_num and exc_src then hold steady until the edge
// where exc_ack=1 is sampled. On that edge exc_valid drops. An exc_ack that
// arrives while exc_valid=0 is ignored.
module exc_vector_unit #(
    parameter int                NUM_SRC    = 4,
    parameter int                INUM_W     = 6,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h02BC,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0028,
    localparam int               SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        exc_req,
    input  logic [NUM_SRC*INUM_W-1:0] exc_req_inum,
    input  logic [NUM_SRC-1:0]        src_enable,
    input  logic [INUM_W-1:0]         head_inum,
    input  logic                      exc_ack,
    input  logic                      flush,
    output logic                      exc_valid,
    output logic [ADDR_W-1:0]         exc_handler_addr,
    output logic [INUM_W-1:0]         exc_inst_num,
    output logic [SRC_W-1:0]          exc_src
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [NUM_SRC-1:0]  pend_q, pend_d;
    logic [INUM_W-1:0]   inum_q [NUM_SRC];
    logic [INUM_W-1:0]   inum_d [NUM_SRC];

    logic                exc_valid_q, exc_valid_d;
    logic [ADDR_W-1:0]   exc_addr_q, exc_addr_d;
    logic [INUM_W-1:0]   exc_inum_q, exc_inum_d;
    logic [SRC_W-1:0]    exc_src_q, exc_src_d;

    logic                any_pend;
    logic                found;
    logic [SRC_W-1:0]    win_idx;
    logic [INUM_W-1:0]   win_inum;
    logic [INUM_W-1:0]   best_age;
    logic [ADDR_W-1:0]   win_addr;
    logic [INUM_W-1:0]   iss_age;
    logic [INUM_W-1:0]   new_inum;

    // Distance from the oldest in-flight instruction; modulo arithmetic handles wrap.
    function automatic logic [INUM_W-1:0] age_of(input logic [INUM_W-1:0] x,
                                                 input logic [INUM_W-1:0] h);
        return x - h;
    endfunction

    // Arbitration: smallest age wins; the strict compare keeps the lowest index on ties.
    always_comb begin
        any_pend = |pend_q;
        found    = 1'b0;
        win_idx  = '0;
        win_inum = '0;
        best_age = '1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_q[i] && (!found || age_of(inum_q[i], head_inum) < best_age)) begin
                found    = 1'b1;
                best_age = age_of(inum_q[i], head_inum);
                win_idx  = SRC_W'(i);
                win_inum = inum_q[i];
            end
        end
        win_addr = VEC_BASE + ADDR_W'(win_idx) * VEC_STRIDE;
    end

    // Pending table update: ack squash first, then new captures, then flush.
    always_comb begin
        pend_d   = pend_q;
        inum_d   = inum_q;
        iss_age  = age_of(exc_inum_q, head_inum);
        new_inum = '0;
        if (state_q == ISSUE && exc_ack) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (SRC_W'(i) == exc_src_q || age_of(inum_q[i], head_inum) >= iss_age) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exc_req[i] && src_enable[i]) begin
                new_inum = exc_req_inum[i*INUM_W +: INUM_W];
                if (!pend_d[i]) begin
                    pend_d[i] = 1'b1;
                    inum_d[i] = new_inum;
                end else if (age_of(new_inum, head_inum) < age_of(inum_d[i], head_inum)) begin
                    inum_d[i] = new_inum;
                end
            end
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    // Issue FSM next state and registered vector outputs.
    always_comb begin
        state_d     = state_q;
        exc_valid_d = exc_valid_q;
        exc_addr_d  = exc_addr_q;
        exc_inum_d  = exc_inum_q;
        exc_src_d   = exc_src_q;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    state_d     = ISSUE;
                    exc_valid_d = 1'b1;
                    exc_addr_d  = win_addr;
                    exc_inum_d  = win_inum;
                    exc_src_d   = win_idx;
                end
            end
            ISSUE: begin
                if (exc_ack) begin
                    state_d     = IDLE;
                    exc_valid_d = 1'b0;
                    exc_addr_d  = '0;
                    exc_inum_d  = '0;
                    exc_src_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            exc_valid_d = 1'b0;
            exc_addr_d  = '0;
            exc_inum_d  = '0;
            exc_src_d   = '0;
        end
    end

    // Pending table registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                inum_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                inum_q[i] <= inum_d[i];
            end
        end
    end

    // FSM state and output registers; reset aborts any in-flight vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
            exc_inum_q  <= '0;
            exc_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            exc_valid_q <= exc_valid_d;
            exc_addr_q  <= exc_addr_d;
            exc_inum_q  <= exc_inum_d;
            exc_src_q   <= exc_src_d;
        end
    end

    assign exc_valid        = exc_valid_q;
    assign exc_handler_addr = exc_addr_q;
    assign exc_inst_num     = exc_inum_q;
    assign exc_src          = exc_src_q;

endmodule

// File: tb/tb_exc_vector_unit.sv
// Bench for exc_vector_unit: directed scenarios followed by random traffic,
// with every cycle compared against a behavioural model of the pending table.
module tb_exc_vector_unit;

  localparam int NS = 4;
  localparam int IW = 6;
  localparam int IMASK = (1 << IW) - 1;

  logic            clk;
  logic            reset_n;
  logic [NS-1:0]   exc_req;
  logic [NS*IW-1:0] exc_req_inum;
  logic [NS-1:0]   src_enable;
  logic [IW-1:0]   head_inum;
  logic            exc_ack;
  logic            flush;
  logic            exc_valid;
  logic [15:0]     exc_handler_addr;
  logic [IW-1:0]   exc_inst_num;
  logic [1:0]      exc_src;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit m_pend[NS];
  int m_inum[NS];
  bit m_issue;
  bit m_valid;
  int m_src;
  int m_inst;
  int m_addr;

  exc_vector_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .exc_req          (exc_req),
    .exc_req_inum     (exc_req_inum),
    .src_enable       (src_enable),
    .head_inum        (head_inum),
    .exc_ack          (exc_ack),
    .flush            (flush),
    .exc_valid        (exc_valid),
    .exc_handler_addr (exc_handler_addr),
    .exc_inst_num     (exc_inst_num),
    .exc_src          (exc_src)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_age(input int x, input int h);
    return (x - h) & IMASK;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 1'b0;
      m_inum[i] = 0;
    end
    m_issue = 1'b0;
    m_valid = 1'b0;
    m_src = 0;
    m_inst = 0;
    m_addr = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it.
  task automatic model_step();
    int  w;
    int  best;
    bit  any;
    int  r;
    int  iss;
    any = 1'b0;
    w = 0;
    best = IMASK + 1;
    for (int i = 0; i < NS; i++) begin
      if (m_pend[i] && m_age(m_inum[i], head_inum) < best) begin
        any = 1'b1;
        best = m_age(m_inum[i], head_inum);
        w = i;
      end
    end
    if (m_issue && exc_ack) begin
      iss = m_age(m_inst, head_inum);
      for (int i = 0; i < NS; i++) begin
        if (i == m_src || m_age(m_inum[i], head_inum) >= iss) m_pend[i] = 1'b0;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (exc_req[i] && src_enable[i]) begin
        r = int'(exc_req_inum[i*IW +: IW]);
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_inum[i] = r;
        end else if (m_age(r, head_inum) < m_age(m_inum[i], head_inum)) begin
          m_inum[i] = r;
        end
      end
    end
    if (!m_issue) begin
      if (any) begin
        m_issue = 1'b1;
        m_valid = 1'b1;
        m_src = w;
        m_inst = best_inum(w);
        m_addr = (16'h02BC + w * 16'h0028) & 16'hFFFF;
      end
    end else if (exc_ack) begin
      m_issue = 1'b0;
      m_valid = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NS; i++) m_pend[i] = 1'b0;
      m_issue = 1'b0;
      m_valid = 1'b0;
    end
  endtask

  // Winner's inum as it stood before this edge (captured in a shadow copy).
  int pre_inum[NS];
  function automatic int best_inum(input int w);
    return pre_inum[w];
  endfunction

  task automatic compare_outputs();
    check("valid", {31'd0, exc_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("addr", {16'd0, exc_handler_addr}, m_addr);
      check("inst_num", {26'd0, exc_inst_num}, m_inst);
      check("src", {30'd0, exc_src}, m_src);
    end
  endtask

  // driver: advance one clock edge, step the model, then compare.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NS; i++) pre_inum[i] = m_inum[i];
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic clr_in();
    exc_req = '0;
    exc_ack = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_req(input int src, input int inum);
    exc_req[src] = 1'b1;
    exc_req_inum[src*IW +: IW] = IW'(inum);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, exc_valid}, 32'd0);
    check("rst_addr", {16'd0, exc_handler_addr}, 32'd0);
    check("rst_inst", {26'd0, exc_inst_num}, 32'd0);
    check("rst_src", {30'd0, exc_src}, 32'd0);
    model_reset();
    clr_in();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic expect_vec(input string tag, input int addr, input int inst, input int src);
    check({tag, "_valid"}, {31'd0, exc_valid}, 32'd1);
    check({tag, "_addr"}, {16'd0, exc_handler_addr}, addr);
    check({tag, "_inst"}, {26'd0, exc_inst_num}, inst);
    check({tag, "_src"}, {30'd0, exc_src}, src);
  endtask

  initial begin
    reset_n = 1'b0;
    exc_req_inum = '0;
    src_enable = '1;
    head_inum = '0;
    clr_in();
    model_reset();
    #3;
    check("por_valid", {31'd0, exc_valid}, 32'd0);
    check("por_addr", {16'd0, exc_handler_addr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // single request
    head_inum = 0;
    set_req(2, 5);
    cycle();
    clr_in();
    check("single_lat", {31'd0, exc_valid}, 32'd0);
    cycle();
    expect_vec("single", 16'h030C, 5, 2);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    check("single_ack", {31'd0, exc_valid}, 32'd0);
    cycle();

    // oldest wins, younger squashed on ack
    set_req(0, 9);
    set_req(3, 4);
    cycle();
    clr_in();
    cycle();
    expect_vec("oldest", 16'h0334, 4, 3);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    cycle();
    cycle();
    check("squash_idle", {31'd0, exc_valid}, 32'd0);

    // wrap-around age
    head_inum = 62;
    set_req(1, 1);
    set_req(0, 63);
    cycle();
    clr_in();
    cycle();
    expect_vec("wrap", 16'h02BC, 63, 0);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    cycle();

    // equal-age tie
    head_inum = 0;
    set_req(1, 7);
    set_req(2, 7);
    cycle();
    clr_in();
    cycle();
    expect_vec("tie", 16'h02E4, 7, 1);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    cycle();

    // hold while unacknowledged, then an older late arrival
    set_req(2, 10);
    cycle();
    clr_in();
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      expect_vec("hold", 16'h030C, 10, 2);
    end
    set_req(1, 8);
    cycle();
    clr_in();
    cycle();
    expect_vec("hold_late", 16'h030C, 10, 2);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    cycle();
    expect_vec("late_next", 16'h02E4, 8, 1);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    cycle();

    // disabled source ignored, ack in idle harmless
    src_enable = 4'b1011;
    set_req(2, 3);
    exc_ack = 1'b1;
    cycle();
    clr_in();
    cycle();
    check("masked", {31'd0, exc_valid}, 32'd0);
    src_enable = '1;

    // flush during issue
    set_req(0, 3);
    cycle();
    clr_in();
    cycle();
    flush = 1'b1;
    set_req(3, 1);
    cycle();
    clr_in();
    check("flush_drop", {31'd0, exc_valid}, 32'd0);
    cycle();
    cycle();
    check("flush_empty", {31'd0, exc_valid}, 32'd0);

    // reset mid-issue
    set_req(1, 2);
    cycle();
    clr_in();
    cycle();
    expect_vec("pre_rst", 16'h02E4, 2, 1);
    apply_reset();
    cycle();
    cycle();
    check("post_rst", {31'd0, exc_valid}, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        exc_req[i] = ($urandom_range(0, 3) == 0);
        exc_req_inum[i*IW +: IW] = IW'($urandom_range(0, IMASK));
      end
      src_enable = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if ($urandom_range(0, 15) == 0) head_inum = IW'($urandom_range(0, IMASK));
      exc_ack = ($urandom_range(0, 9) < 4);
      flush = ($urandom_range(0, 39) == 0);
      cycle();
      if ($urandom_range(0, 499) == 0) apply_reset();
    end
    clr_in();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exc_vector_unit.md
EXC_VECTOR_UNIT -- requirements
Module: exc_vector_unit

Interface
REQ-001 Parameter NUM_SRC, default 4: number of exception sources; source 0 has the highest tie priority.
REQ-002 Parameter INUM_W, default 6: instruction-number width.
REQ-003 Parameter ADDR_W, default 16: handler-address width.
REQ-004 Parameter VEC_BASE, default 16'h02BC: handler address of source 0.
REQ-005 Parameter VEC_STRIDE, default 16'h0028: address spacing between consecutive sources' handlers.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 exc_req  in  NUM_SRC  per-source exception request, one-cycle pulse or level.
REQ-009 exc_req_inum  in  NUM_SRC*INUM_W  instruction number per source; slice i belongs to source i.
REQ-010 src_enable  in  NUM_SRC  per-source mask; a disabled source's requests are ignored.
REQ-011 head_inum  in  INUM_W  instruction number of the oldest in-flight instruction, used as the age origin.
REQ-012 exc_ack  in  1  the commit stage accepted the issued exception.
REQ-013 flush  in  1  external pipeline flush.
REQ-014 exc_valid  out  1  an exception vector is being presented.
REQ-015 exc_handler_addr  out  ADDR_W  vector address.
REQ-016 exc_inst_num  out  INUM_W  faulting instruction number.
REQ-017 exc_src  out  clog2(NUM_SRC)  index of the winning source.

Function
REQ-018 Age of instruction number x SHALL be (x - head_inum) mod 2^INUM_W; a smaller age is older, and wrap-around is handled by this modulo.
REQ-019 Each source SHALL hold one pending bit plus a stored inum.
  - Request while the source is not pending: set the bit and store the inum on the next edge.
  - Request while already pending: keep whichever of the stored and new inums is older.
REQ-020 Arbitration SHALL select the pending source with the smallest age; equal ages resolve to the lowest source index.
REQ-021 FSM states SHALL be IDLE and ISSUE.
REQ-022 IDLE -> ISSUE occurs on the first edge where any bit is pending. On that edge the unit registers:
  - exc_valid = 1
  - exc_src = winner
  - exc_inst_num = winner's stored inum
  - exc_handler_addr = VEC_BASE + winner*VEC_STRIDE, truncated to ADDR_W
REQ-023 Latency: a request sampled at edge E0 SHALL produce exc_valid=1 after edge E1 when the unit is IDLE with nothing pending.
REQ-024 In ISSUE, all outputs SHALL stay frozen until exc_ack; pending capture continues meanwhile.
REQ-025 On an edge with exc_ack=1 in ISSUE, the unit SHALL:
  - return to IDLE and drive exc_valid=0;
  - clear the winner's pending bit;
  - clear every pending entry whose age is not older than the issued instruction's age (younger ones are squashed).
  Entries older than the issued instruction remain pending and re-arbitrate.
REQ-026 A request arriving in the exc_ack cycle SHALL be captured after the squash evaluation and obeys REQ-019.
REQ-027 flush=1 SHALL clear all pending bits on the next edge, ignore same-cycle requests, and force IDLE with exc_valid=0. exc_ack and flush together: ack processing occurs, then everything is cleared.
REQ-028 exc_ack while in IDLE SHALL have no effect.
REQ-029 Changes to src_enable SHALL NOT clear already-pending entries.

Reset
REQ-030 reset_n=0 SHALL immediately clear all pending bits and stored inums, set the state to IDLE, and drive all outputs to 0.
REQ-031 Reset asserted mid-ISSUE SHALL abort the exception; no vector survives reset.

Verification
REQ-032 Single request: head=0, source 2 requests inum 5 -> two edges later exc_valid=1, addr=16'h030C, inst_num=5, src=2.
REQ-033 Oldest wins: head=0, source 0 requests inum 9 and source 3 requests inum 4 in the same cycle -> src=3, addr=16'h0334, inst_num=4. After ack, source 0's entry (inum 9, younger) is squashed and exc_valid stays 0.
REQ-034 Wrap-around and tie:
  - head=62, source 1 requests inum 1 and source 0 requests inum 63 -> source 0 wins (age 1 vs 3).
  - Sources 1 and 2 both request inum 7 -> source 1 wins.
REQ-035 Hold and older late arrival: source 2 issued with inum 10 and no ack for 5 cycles -> outputs remain constant. Source 1 then requests inum 8 (head=0) -> after ack, source 1 issues next with addr=16'h02E4.
REQ-036 Flush and reset: flush during ISSUE -> exc_valid=0 next edge with nothing pending. reset_n pulsed low mid-ISSUE -> outputs 0 asynchronously and the unit is IDLE after release.
